pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Parametrised successor to the single-adder jump-target block. Owns the program counter and computes JAL, branch and JALR targets internally. Drives the fetch handshake, flushes on taken redirects, raises a sticky misaligned-target trap, and keeps a saturating redirect counter. Sits between the execute-stage branch/jump decision and the instruction-fetch stage of the RV32I core.

Parameters:
XLEN, 32, datapath width of PC, operands and targets
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte IALIGN)
CNT_W, 16, width of the redirect counter

Ports:
ip_clk  in  1  clock, rising edge
ip_rst  in  1  synchronous, active-high reset
ip_Fetch_Ready  in  1  fetch stage accepts op_PC this cycle
ip_Redirect_Valid  in  1  execute presents a control-transfer request
ip_Mode  in  2  00 JAL, 01 BRANCH, 10 JALR, 11 reserved
ip_Taken  in  1  branch outcome; used only in BRANCH mode
ip_Base_PC  in  XLEN  PC of the jump/branch instruction
ip_Base_Rs1  in  XLEN  rs1 value for JALR
ip_Offset  in  XLEN  sign-extended immediate, already shifted
op_PC  out  XLEN  current fetch PC
op_Fetch_Valid  out  1  op_PC is valid for fetch
op_Flush  out  1  one-cycle pulse on an accepted redirect
op_Link  out  XLEN  registered ip_Base_PC+4 of the last JAL/JALR
op_Link_Valid  out  1  one-cycle pulse with op_Link
op_Trap  out  1  sticky misaligned-target trap
op_Trap_Addr  out  XLEN  offending target address
op_Redirect_Cnt  out  CNT_W  saturating count of accepted redirects

Behaviour:
- All registers update on the rising edge of ip_clk. ip_rst is synchronous and active-high and overrides everything.
- Reset values: op_PC=RESET_VECTOR, op_Fetch_Valid=0, op_Flush=0, op_Link=0, op_Link_Valid=0, op_Trap=0, op_Trap_Addr=0, op_Redirect_Cnt=0, state=BOOT.
- FSM states: BOOT, RUN, TRAP.
  - BOOT -> RUN unconditionally one cycle after reset is released. op_Fetch_Valid is 1 from the first RUN cycle.
  - RUN -> TRAP on a misaligned accepted redirect.
  - TRAP is left only by ip_rst. In TRAP: op_Fetch_Valid=0, PC frozen, all inputs ignored.
- Accepted redirect (RUN only) means ip_Redirect_Valid=1 and one of:
  - ip_Mode=JAL;
  - ip_Mode=JALR;
  - ip_Mode=BRANCH with ip_Taken=1.
  BRANCH with ip_Taken=0 and Mode=11 are ignored: no flush, no count.
- Target computation, modulo 2^XLEN with carry discarded (wrap at top of address space is legal):
  - JAL/BRANCH: ip_Base_PC+ip_Offset.
  - JALR: (ip_Base_Rs1+ip_Offset) with bit0 cleared.
- Aligned target, next cycle:
  - op_PC=target, op_Flush=1, op_Redirect_Cnt+1 (holds at all-ones).
  - For JAL/JALR also op_Link=ip_Base_PC+4 and op_Link_Valid=1.
- Misaligned target (target[ALIGN_BITS-1:0]!=0 after the JALR clear), next cycle:
  - op_Trap=1, op_Trap_Addr=target, op_Fetch_Valid=0, state=TRAP.
  - No flush, no link, no count; op_PC keeps its old value.
- No accepted redirect in RUN:
  - op_Fetch_Valid&&ip_Fetch_Ready: op_PC += 4, wrapping.
  - Otherwise op_PC holds (stall).
- Priority: an accepted redirect wins over a same-cycle fetch handshake. The fetched PC is dropped and not incremented, and the redirect is taken even when ip_Fetch_Ready=0.
- Latency: redirect request to new op_PC is 1 cycle. op_Flush, op_Link_Valid and op_Trap assert in that same cycle.
- Reset asserted mid-redirect or in TRAP: the reset values above apply on the next edge; the pending redirect is discarded.

Decomposition:
- Shared package rv32i_pkg: mode encodings (MODE_JAL, MODE_BRANCH, MODE_JALR), FSM state encodings, constant INSTR_BYTES=4.
- One natural sub-module: target_adder, a parametrised XLEN combinational adder with a JALR bit0-clear mode and an ALIGN_BITS misalignment flag output. It replaces the old fixed-width jump adder.

Test Plan:
- Reset then ready held high -> BOOT cycle with valid=0, then op_PC = 0, 4, 8, 12 on consecutive cycles.
- ip_Fetch_Ready=0 for 3 cycles at PC=8 -> op_PC stays 8 and valid stays 1; release -> 12.
- JAL, Base_PC=0x100, Offset=0xFFFF_FFF0 -> op_PC=0xF0, Flush=1, Link=0x104, Link_Valid=1, Cnt=1. Same-cycle ready=1 does not yield 0x104.
- BRANCH with Taken=0 -> no flush and PC+4. JALR with Rs1=0x201, Offset=0x3 -> target 0x204, Flush=1.
- JAL from Base_PC=0x10 with Offset=0x2 -> op_Trap=1, Trap_Addr=0x12, valid=0, PC held. Further redirects ignored until ip_rst, which restores RESET_VECTOR.
- Wrap and saturation: JAL with Base_PC=0xFFFF_FFFC, Offset=0x8 -> op_PC=0x4. With CNT_W=2, five accepted redirects -> Cnt saturates at 3.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end encodings: control-transfer modes, PC-unit FSM states,
// and the fixed instruction size used for sequential fetch and link addresses.
package rv32i_pkg;

    typedef enum logic [1:0] {
        MODE_JAL    = 2'b00,
        MODE_BRANCH = 2'b01,
        MODE_JALR   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/target_adder.sv
// Combinational control-transfer target adder: base + offset (carry dropped),
// optional JALR bit-0 clear, and a flag for targets violating instruction alignment.
module target_adder #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic [XLEN-1:0] ip_Base,
    input  logic [XLEN-1:0] ip_Offset,
    input  logic            ip_Clear_Bit0,
    output logic [XLEN-1:0] op_Target,
    output logic            op_Misaligned
);

    logic [XLEN-1:0] sum;

    assign sum = ip_Base + ip_Offset;

    // Alignment is judged on the final target, after the JALR clear.
    assign op_Target     = ip_Clear_Bit0 ? {sum[XLEN-1:1], 1'b0} : sum;
    assign op_Misaligned = |op_Target[ALIGN_BITS-1:0];

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter owner: sequential fetch, JAL/BRANCH/JALR redirects with flush and
// link, sticky misaligned-target trap, and a saturating count of accepted redirects.
module pc_next_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic             ip_clk,
    input  logic             ip_rst,
    input  logic             ip_Fetch_Ready,
    input  logic             ip_Redirect_Valid,
    input  logic [1:0]       ip_Mode,
    input  logic             ip_Taken,
    input  logic [XLEN-1:0]  ip_Base_PC,
    input  logic [XLEN-1:0]  ip_Base_Rs1,
    input  logic [XLEN-1:0]  ip_Offset,
    output logic [XLEN-1:0]  op_PC,
    output logic             op_Fetch_Valid,
    output logic             op_Flush,
    output logic [XLEN-1:0]  op_Link,
    output logic             op_Link_Valid,
    output logic             op_Trap,
    output logic [XLEN-1:0]  op_Trap_Addr,
    output logic [CNT_W-1:0] op_Redirect_Cnt,
    output logic [1:0]       op_Dbg_State
);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  link_q, link_d;
    logic [XLEN-1:0]  trap_addr_q, trap_addr_d;
    logic             flush_q, flush_d;
    logic             link_valid_q, link_valid_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mode_e           mode;
    logic            is_jalr;
    logic            accept;
    logic            misaligned;
    logic [XLEN-1:0] adder_base;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;

    assign mode       = mode_e'(ip_Mode);
    assign is_jalr    = (mode == MODE_JALR);
    assign accept     = ip_Redirect_Valid &&
                        ((mode == MODE_JAL) || is_jalr ||
                         ((mode == MODE_BRANCH) && ip_Taken));
    assign adder_base = is_jalr ? ip_Base_Rs1 : ip_Base_PC;
    assign link_addr  = ip_Base_PC + XLEN'(INSTR_BYTES);

    target_adder #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_target_adder (
        .ip_Base       (adder_base),
        .ip_Offset     (ip_Offset),
        .ip_Clear_Bit0 (is_jalr),
        .op_Target     (target),
        .op_Misaligned (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        link_d       = link_q;
        trap_addr_d  = trap_addr_q;
        trap_d       = trap_q;
        cnt_d        = cnt_q;
        flush_d      = 1'b0;
        link_valid_d = 1'b0;

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                // A redirect beats the fetch handshake even when fetch is stalled.
                if (accept) begin
                    if (misaligned) begin
                        trap_d      = 1'b1;
                        trap_addr_d = target;
                        state_d     = ST_TRAP;
                    end else begin
                        pc_d    = target;
                        flush_d = 1'b1;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        if (mode != MODE_BRANCH) begin
                            link_d       = link_addr;
                            link_valid_d = 1'b1;
                        end
                    end
                end else if (ip_Fetch_Ready) begin
                    pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            link_q       <= '0;
            trap_addr_q  <= '0;
            trap_q       <= 1'b0;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            link_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            link_q       <= link_d;
            trap_addr_q  <= trap_addr_d;
            trap_q       <= trap_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            link_valid_q <= link_valid_d;
        end
    end

    // Fetch is offered exactly while running; BOOT and TRAP both suppress it.
    assign op_Fetch_Valid  = (state_q == ST_RUN);
    assign op_PC           = pc_q;
    assign op_Flush        = flush_q;
    assign op_Link         = link_q;
    assign op_Link_Valid   = link_valid_q;
    assign op_Trap         = trap_q;
    assign op_Trap_Addr    = trap_addr_q;
    assign op_Redirect_Cnt = cnt_q;
    assign op_Dbg_State    = state_q;

endmodule
